// File: rtl/ysyx_23060201_lsu_load.sv
// Load-side memory port: one load in flight, fixed-latency memory read,
// byte/half extraction with sign/zero extension, misaligned/illegal detection.
module ysyx_23060201_lsu_load #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;

    // Behavioural stand-in for the simulator's memory: a small word array
    // plus a count of reads, both reachable hierarchically from a bench.
    logic [31:0] sim_mem [16] = '{default: '0};
    int unsigned pmem_reads = 0;

    function automatic int pmem_read(input int raddr);
        return int'(sim_mem[4'((raddr >> 2) & 32'hF)]);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst && state == WAIT && cnt == '0)
            pmem_reads <= pmem_reads + 1;
    end

    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0, 3'd4: is_illegal = 1'b0;
            3'd1, 3'd5: is_illegal = a[0];
            3'd2:       is_illegal = |a;
            default:    is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'd0:    extend = {{24{b[7]}}, b};
            3'd4:    extend = {24'd0, b};
            3'd1:    extend = {{16{h[15]}}, h};
            3'd5:    extend = {16'd0, h};
            default: extend = w;
        endcase
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid)
                      state_nx = is_illegal(req_funct3, req_addr[1:0]) ? RESP : WAIT;
            WAIT: if (cnt == '0) state_nx = RESP;
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            addr_q    <= '0;
            funct3_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    funct3_q <= req_funct3;
                    if (is_illegal(req_funct3, req_addr[1:0])) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end else begin
                        cnt <= CW'(LATENCY - 1);
                    end
                end
                WAIT: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    resp_data <= DATA_WIDTH'(extend(
                        32'(pmem_read(int'({addr_q[ADDR_WIDTH-1:2], 2'b00}))),
                        addr_q[1:0], funct3_q));
                    resp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
